lsu_mem_unit: RTL and testbench
===============================

Name: lsu_mem_unit

Overview:
- Parametrised load/store unit for the npc core.
- Replaces the fixed single-cycle lw/lbu/sw/sb memory path with a multi-cycle, handshaked engine.
- Supports all RV32/RV64 load/store sizes, with sign/zero extension, byte-lane steering and write masks.
- Core side: valid/ready request plus a one-cycle response pulse. Memory side: valid/ready request plus rvalid read return. A timeout guards against a dead bus.

Parameters:
- DATA_W, 32, memory/register data width in bits; legal values 32 or 64.
- ADDR_W, 32, address width in bits.
- TIMEOUT, 255, maximum cycles waiting for mem_ready or mem_rvalid before an error response; 0 disables the timeout.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  1  core request valid
- req_ready  out  1  unit can accept a request (high only in IDLE)
- req_store  in  1  1 = store, 0 = load
- req_funct3  in  3  RISC-V funct3: [1:0] size (0=B, 1=H, 2=W, 3=D), [2] unsigned-load flag
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  store data, right-aligned
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  DATA_W  extended load data (0 for stores)
- resp_err  out  1  error qualifier, valid with resp_valid
- mem_valid  out  1  memory request valid
- mem_ready  in  1  memory accepts the request
- mem_we  out  1  write enable
- mem_addr  out  ADDR_W  DATA_W/8-aligned address (low OFF_W bits zero)
- mem_wdata  out  DATA_W  lane-shifted store data
- mem_wmask  out  DATA_W/8  byte-enable mask
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  full-width read word

Behaviour:
- OFF_W = log2(DATA_W/8).
- Reset: state=IDLE; req_ready=1; resp_valid=0; resp_err=0; resp_rdata=0; mem_valid=0; mem_we=0; mem_wmask=0; timeout counter=0. Reset asserted mid-transaction abandons it; no resp_valid is issued.
- States:
  - IDLE: req_ready=1. On req_valid, latch all req_* fields and go to REQ.
  - REQ: mem_valid=1, all mem_* outputs driven from the latched fields. On mem_ready: store -> RESP; load -> WAIT_R.
  - WAIT_R: wait for mem_rvalid, then capture and extend mem_rdata and go to RESP. An mem_rvalid arriving while in REQ is ignored.
  - RESP: resp_valid=1 for exactly one cycle, then IDLE.
- Minimum latency, req accept to resp_valid: store 2 cycles, load 3 cycles.
- Illegal size: funct3 size 3 when DATA_W=32, or funct3=111. Go directly IDLE -> RESP with resp_err=1, no memory access, resp_rdata=0.
- Store lanes:
  - off = addr[OFF_W-1:0]
  - mem_wdata = req_wdata << (8*off)
  - mem_wmask = ((1<<bytes)-1) << off, where bytes = 1/2/4/8
- Load extraction: shift mem_rdata right by 8*off, truncate to the access size, then sign-extend (funct3[2]=0) or zero-extend (funct3[2]=1) to DATA_W. W-loads on DATA_W=64 sign-extend (lw) or zero-extend (lwu).
- Timeout:
  - The counter clears on entry to REQ and to WAIT_R, and increments each cycle spent in either state.
  - Reaching TIMEOUT -> RESP with resp_err=1, mem_valid dropped, resp_rdata=0.
  - A late mem_rvalid arriving in IDLE is ignored.
- A single outstanding transaction only. A new request is accepted no earlier than the cycle after RESP.

Optional Feature:
- Macro: LSU_MISALIGN_EXC_EN.
- Defined: an access with addr mod bytes != 0 receives an immediate error response (IDLE -> RESP, resp_err=1) and causes no memory traffic.
- Undefined: misaligned accesses proceed. Lane bytes beyond the word boundary are dropped from mem_wmask, and the missing load bytes read as 0 before extension. No error is raised.

Decomposition:
- Package npc_lsu_pkg holds:
  - the state enum (IDLE, REQ, WAIT_R, RESP)
  - funct3 size constants SZ_B=0, SZ_H=1, SZ_W=2, SZ_D=3
  - an is_unsigned bit-position constant
- Sub-module lsu_lane_align (combinational) takes offset, size and unsigned flag and produces the store data/mask and the extended load data. It is shared by both directions and unit-tested separately.

Test Plan:
- DATA_W=32; lbu at addr 0x80000003, mem_rdata=0xAB000000 -> resp_rdata=0x000000AB. Same as lb -> 0xFFFFFFAB. Load latency 3 cycles with mem_ready and mem_rvalid immediate.
- sh at 0x80000002 with wdata=0x1234BEEF -> mem_addr=0x80000000, mem_wdata[31:16]=0xBEEF, mem_wmask=4'b1100, mem_we=1; resp_valid 2 cycles after accept.
- DATA_W=64; ld at 0x10 with mem_rdata=0x8000_0000_0000_0001 -> resp_rdata unchanged. lw at 0x14 with the same data -> 0xFFFFFFFF80000000. lwu at 0x14 -> 0x0000000080000000.
- mem_ready held low for 3 cycles -> mem_valid stays high and all mem_* outputs stay stable, with no resp_valid until after the handshake. With TIMEOUT=4 and mem_rvalid never asserted -> resp_err=1 after 4 WAIT_R cycles.
- ld with DATA_W=32 -> resp_err=1 and mem_valid never asserted. Reset pulsed while in WAIT_R -> next cycle is IDLE with req_ready=1 and no resp_valid.
- With LSU_MISALIGN_EXC_EN defined, lw at 0x81 -> resp_err=1 and no mem_valid. Without the macro, the same access -> mem_wmask/extraction covers bytes 1..3 only and resp_err=0.

Source files
------------

// File: rtl/npc_lsu_pkg.sv
// ---------------------------------------------------------------------------
// npc_lsu_pkg
// Shared types and constants for the npc load/store unit.
//   lsu_state_e      : FSM state encoding (IDLE, REQ, WAIT_R, RESP)
//   SZ_B..SZ_D       : funct3[1:0] access-size codes
//   F3_UNSIGNED_BIT  : funct3 bit that selects zero-extension on loads
//   size_base_mask() : byte-enable pattern of an access before lane shifting
// ---------------------------------------------------------------------------
package npc_lsu_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    WAIT_R = 2'd2,
    RESP   = 2'd3
  } lsu_state_e;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  localparam int F3_UNSIGNED_BIT = 2;

  function automatic logic [7:0] size_base_mask(input logic [1:0] sz);
    case (sz)
      SZ_B:    return 8'h01;
      SZ_H:    return 8'h03;
      SZ_W:    return 8'h0F;
      default: return 8'hFF;
    endcase
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
// Combinational byte-lane steering shared by stores and loads.
//   off_i      : byte offset of the access inside the memory word
//   size_i     : funct3[1:0] access size
//   unsigned_i : 1 = zero-extend loads, 0 = sign-extend
//   st_data_i  : right-aligned store data
//   st_data_o  : store data shifted onto its byte lanes
//   st_mask_o  : byte enables; lanes past the word boundary are dropped
//   ld_word_i  : full-width word returned by memory
//   ld_data_o  : load data shifted down, truncated and extended
// ---------------------------------------------------------------------------
module lsu_lane_align
  import npc_lsu_pkg::*;
#(
  parameter  int DATA_W = 32,
  localparam int BYTES  = DATA_W / 8,
  localparam int OFF_W  = $clog2(BYTES)
) (
  input  logic [OFF_W-1:0]  off_i,
  input  logic [1:0]        size_i,
  input  logic              unsigned_i,
  input  logic [DATA_W-1:0] st_data_i,
  output logic [DATA_W-1:0] st_data_o,
  output logic [BYTES-1:0]  st_mask_o,
  input  logic [DATA_W-1:0] ld_word_i,
  output logic [DATA_W-1:0] ld_data_o
);

  logic [7:0]          base8;
  logic [2*BYTES-1:0]  mask_wide;
  logic [DATA_W-1:0]   ld_shift;
  logic [DATA_W-1:0]   keep_m;
  logic                sign_b;

  assign base8 = size_base_mask(size_i);

  // Shift into a double-width field so lanes that fall off the top of the
  // word simply disappear when truncated.
  assign mask_wide = {{BYTES{1'b0}}, base8[BYTES-1:0]} << off_i;
  assign st_mask_o = mask_wide[BYTES-1:0];
  assign st_data_o = st_data_i << {off_i, 3'b000};

  // Missing upper bytes of a misaligned load shift in as zero.
  assign ld_shift = ld_word_i >> {off_i, 3'b000};

  always_comb begin
    keep_m = '1;
    sign_b = 1'b0;
    case (size_i)
      SZ_B: begin
        keep_m = DATA_W'(8'hFF);
        sign_b = ld_shift[7];
      end
      SZ_H: begin
        keep_m = DATA_W'(16'hFFFF);
        sign_b = ld_shift[15];
      end
      SZ_W: begin
        keep_m = DATA_W'(32'hFFFF_FFFF);
        sign_b = ld_shift[31];
      end
      default: begin
        keep_m = '1;
        sign_b = 1'b0;
      end
    endcase
  end

  assign ld_data_o = (ld_shift & keep_m) | ((sign_b & ~unsigned_i) ? ~keep_m : '0);

endmodule

// File: rtl/lsu_mem_unit.sv
// ---------------------------------------------------------------------------
// lsu_mem_unit
// Multi-cycle handshaked load/store engine for the npc core.
// Core side : req_valid_i/req_ready_o request, one-cycle resp_valid_o pulse
//             with resp_rdata_o (extended load data) and resp_err_o.
// Memory    : mem_valid_o/mem_ready_i request carrying mem_we_o, aligned
//             mem_addr_o, lane-shifted mem_wdata_o and mem_wmask_o; read data
//             returns on mem_rvalid_i/mem_rdata_i.
// Parameters: DATA_W (32 or 64), ADDR_W, TIMEOUT (0 = no timeout).
// Build option: define LSU_MISALIGN_EXC_EN to turn misaligned accesses into
// an immediate error response instead of a partial-lane access.
//
// state  | meaning
// -------+--------------------------------------------------------------
// IDLE   | ready for a request; illegal/misaligned requests skip to RESP
// REQ    | mem_valid_o held with stable fields until mem_ready_i
// WAIT_R | load issued, waiting for mem_rvalid_i
// RESP   | one-cycle resp_valid_o, then back to IDLE
// ---------------------------------------------------------------------------
module lsu_mem_unit
  import npc_lsu_pkg::*;
#(
  parameter  int DATA_W  = 32,
  parameter  int ADDR_W  = 32,
  parameter  int TIMEOUT = 255,
  localparam int BYTES   = DATA_W / 8
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic              req_store_i,
  input  logic [2:0]        req_funct3_i,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic [DATA_W-1:0] req_wdata_i,
  output logic              resp_valid_o,
  output logic [DATA_W-1:0] resp_rdata_o,
  output logic              resp_err_o,
  output logic              mem_valid_o,
  input  logic              mem_ready_i,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  output logic [BYTES-1:0]  mem_wmask_o,
  input  logic              mem_rvalid_i,
  input  logic [DATA_W-1:0] mem_rdata_i
);

  localparam int OFF_W = $clog2(BYTES);
  localparam int CNT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // Counter value during the last permitted cycle of REQ/WAIT_R.
  localparam logic [CNT_W-1:0] TO_LAST = CNT_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  lsu_state_e        state_q;
  logic              req_ready_q;
  logic              resp_valid_q;
  logic              resp_err_q;
  logic [DATA_W-1:0] resp_rdata_q;
  logic              mem_valid_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] mem_addr_q;
  logic [DATA_W-1:0] mem_wdata_q;
  logic [BYTES-1:0]  mem_wmask_q;
  logic [CNT_W-1:0]  to_cnt_q;
  logic              store_q;
  logic [1:0]        size_q;
  logic              uns_q;
  logic [OFF_W-1:0]  off_q;

  logic              idle_w;
  logic              illegal_w;
  logic              misalign_w;
  logic              to_hit_w;
  logic [OFF_W-1:0]  al_off;
  logic [1:0]        al_size;
  logic              al_uns;
  logic [DATA_W-1:0] al_st_data;
  logic [BYTES-1:0]  al_st_mask;
  logic [DATA_W-1:0] al_ld_data;

  assign idle_w = (state_q == IDLE);

  // The aligner sees the live request while idle (store lanes are computed
  // at accept time) and the latched fields afterwards (load extraction).
  assign al_off  = idle_w ? req_addr_i[OFF_W-1:0] : off_q;
  assign al_size = idle_w ? req_funct3_i[1:0] : size_q;
  assign al_uns  = idle_w ? req_funct3_i[F3_UNSIGNED_BIT] : uns_q;

  lsu_lane_align #(
    .DATA_W (DATA_W)
  ) u_align (
    .off_i      (al_off),
    .size_i     (al_size),
    .unsigned_i (al_uns),
    .st_data_i  (req_wdata_i),
    .st_data_o  (al_st_data),
    .st_mask_o  (al_st_mask),
    .ld_word_i  (mem_rdata_i),
    .ld_data_o  (al_ld_data)
  );

  assign illegal_w = (req_funct3_i == 3'b111) ||
                     ((req_funct3_i[1:0] == SZ_D) && (DATA_W == 32));

  always_comb begin
    misalign_w = 1'b0;
`ifdef LSU_MISALIGN_EXC_EN
    case (req_funct3_i[1:0])
      SZ_H:    misalign_w = req_addr_i[0];
      SZ_W:    misalign_w = |req_addr_i[1:0];
      SZ_D:    misalign_w = |req_addr_i[2:0];
      default: misalign_w = 1'b0;
    endcase
`endif
  end

  assign to_hit_w = (TIMEOUT != 0) && (to_cnt_q == TO_LAST);

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      req_ready_q  <= 1'b1;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      resp_rdata_q <= '0;
      mem_valid_q  <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_wmask_q  <= '0;
      to_cnt_q     <= '0;
      store_q      <= 1'b0;
      size_q       <= SZ_B;
      uns_q        <= 1'b0;
      off_q        <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (req_valid_i) begin
            req_ready_q <= 1'b0;
            store_q     <= req_store_i;
            size_q      <= req_funct3_i[1:0];
            uns_q       <= req_funct3_i[F3_UNSIGNED_BIT];
            off_q       <= req_addr_i[OFF_W-1:0];
            if (illegal_w || misalign_w) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b1;
              resp_rdata_q <= '0;
            end else begin
              state_q     <= REQ;
              mem_valid_q <= 1'b1;
              mem_we_q    <= req_store_i;
              mem_addr_q  <= {req_addr_i[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
              mem_wdata_q <= al_st_data;
              mem_wmask_q <= al_st_mask;
              to_cnt_q    <= '0;
            end
          end
        end

        REQ: begin
          if (mem_ready_i) begin
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_wmask_q <= '0;
            if (store_q) begin
              state_q      <= RESP;
              resp_valid_q <= 1'b1;
              resp_err_q   <= 1'b0;
              resp_rdata_q <= '0;
            end else begin
              state_q  <= WAIT_R;
              to_cnt_q <= '0;
            end
          end else if (to_hit_w) begin
            mem_valid_q  <= 1'b0;
            mem_we_q     <= 1'b0;
            mem_wmask_q  <= '0;
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
          end
        end

        WAIT_R: begin
          if (mem_rvalid_i) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= al_ld_data;
          end else if (to_hit_w) begin
            state_q      <= RESP;
            resp_valid_q <= 1'b1;
            resp_err_q   <= 1'b1;
            resp_rdata_q <= '0;
          end else begin
            to_cnt_q <= to_cnt_q + CNT_W'(1);
          end
        end

        RESP: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end

        default: begin
          state_q     <= IDLE;
          req_ready_q <= 1'b1;
        end
      endcase
    end
  end

  assign req_ready_o  = req_ready_q;
  assign resp_valid_o = resp_valid_q;
  assign resp_err_o   = resp_err_q;
  assign resp_rdata_o = resp_rdata_q;
  assign mem_valid_o  = mem_valid_q;
  assign mem_we_o     = mem_we_q;
  assign mem_addr_o   = mem_addr_q;
  assign mem_wdata_o  = mem_wdata_q;
  assign mem_wmask_o  = mem_wmask_q;

endmodule

// File: tb/tb_lsu_mem_unit.sv
// Directed bench: one 32-bit instance (TIMEOUT=255) and one 64-bit instance
// (TIMEOUT=4) share a clock and reset; `sel` routes the stimulus to one of them.
module tb_lsu_mem_unit;

  logic clk = 1'b0;
  logic reset;
  logic sel;

  logic        r_valid;
  logic        r_store;
  logic [2:0]  r_f3;
  logic [31:0] r_addr;
  logic [63:0] r_wdata;
  logic        m_ready;
  logic        m_rvalid;
  logic [63:0] m_rdata;

  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_resp_valid, a_resp_err;
  logic        a_mem_valid, a_mem_ready, a_mem_we, a_mem_rvalid;
  logic [31:0] a_resp_rdata, a_mem_addr, a_mem_wdata;
  logic [3:0]  a_mem_wmask;

  logic        b_req_valid, b_req_ready, b_resp_valid, b_resp_err;
  logic        b_mem_valid, b_mem_ready, b_mem_we, b_mem_rvalid;
  logic [63:0] b_resp_rdata, b_mem_wdata;
  logic [31:0] b_mem_addr;
  logic [7:0]  b_mem_wmask;

  assign a_req_valid  = r_valid & ~sel;
  assign a_mem_ready  = m_ready & ~sel;
  assign a_mem_rvalid = m_rvalid & ~sel;
  assign b_req_valid  = r_valid & sel;
  assign b_mem_ready  = m_ready & sel;
  assign b_mem_rvalid = m_rvalid & sel;

  lsu_mem_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT(255)) u_a (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(a_req_valid), .req_ready_o(a_req_ready),
    .req_store_i(r_store), .req_funct3_i(r_f3), .req_addr_i(r_addr),
    .req_wdata_i(r_wdata[31:0]),
    .resp_valid_o(a_resp_valid), .resp_rdata_o(a_resp_rdata), .resp_err_o(a_resp_err),
    .mem_valid_o(a_mem_valid), .mem_ready_i(a_mem_ready), .mem_we_o(a_mem_we),
    .mem_addr_o(a_mem_addr), .mem_wdata_o(a_mem_wdata), .mem_wmask_o(a_mem_wmask),
    .mem_rvalid_i(a_mem_rvalid), .mem_rdata_i(m_rdata[31:0])
  );

  lsu_mem_unit #(.DATA_W(64), .ADDR_W(32), .TIMEOUT(4)) u_b (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(b_req_valid), .req_ready_o(b_req_ready),
    .req_store_i(r_store), .req_funct3_i(r_f3), .req_addr_i(r_addr),
    .req_wdata_i(r_wdata),
    .resp_valid_o(b_resp_valid), .resp_rdata_o(b_resp_rdata), .resp_err_o(b_resp_err),
    .mem_valid_o(b_mem_valid), .mem_ready_i(b_mem_ready), .mem_we_o(b_mem_we),
    .mem_addr_o(b_mem_addr), .mem_wdata_o(b_mem_wdata), .mem_wmask_o(b_mem_wmask),
    .mem_rvalid_i(b_mem_rvalid), .mem_rdata_i(m_rdata)
  );

  logic        o_req_ready, o_resp_valid, o_resp_err, o_mem_valid, o_mem_we;
  logic [63:0] o_resp_rdata, o_mem_wdata;
  logic [31:0] o_mem_addr;
  logic [7:0]  o_mem_wmask;

  assign o_req_ready  = sel ? b_req_ready  : a_req_ready;
  assign o_resp_valid = sel ? b_resp_valid : a_resp_valid;
  assign o_resp_err   = sel ? b_resp_err   : a_resp_err;
  assign o_mem_valid  = sel ? b_mem_valid  : a_mem_valid;
  assign o_mem_we     = sel ? b_mem_we     : a_mem_we;
  assign o_resp_rdata = sel ? b_resp_rdata : {32'h0, a_resp_rdata};
  assign o_mem_wdata  = sel ? b_mem_wdata  : {32'h0, a_mem_wdata};
  assign o_mem_addr   = sel ? b_mem_addr   : a_mem_addr;
  assign o_mem_wmask  = sel ? b_mem_wmask  : {4'h0, a_mem_wmask};

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic st, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [63:0] wd);
    r_valid = 1'b1;
    r_store = st;
    r_f3    = f3;
    r_addr  = addr;
    r_wdata = wd;
    step();
    r_valid = 1'b0;
  endtask

  // Load with mem_ready and mem_rvalid immediate: resp_valid on the 3rd edge.
  task automatic do_load(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                         input logic [31:0] exp_addr, input logic [7:0] exp_mask,
                         input logic [63:0] rdata, input logic [63:0] exp_data);
    issue(1'b0, f3, addr, 64'h0);
    chk({tag, ".mem_valid"}, {63'h0, o_mem_valid}, 64'h1);
    chk({tag, ".mem_we"}, {63'h0, o_mem_we}, 64'h0);
    chk({tag, ".mem_addr"}, {32'h0, o_mem_addr}, {32'h0, exp_addr});
    chk({tag, ".mem_wmask"}, {56'h0, o_mem_wmask}, {56'h0, exp_mask});
    chk({tag, ".req_ready"}, {63'h0, o_req_ready}, 64'h0);
    m_ready = 1'b1;
    step();
    m_ready  = 1'b0;
    m_rvalid = 1'b1;
    m_rdata  = rdata;
    chk({tag, ".early_resp"}, {63'h0, o_resp_valid}, 64'h0);
    chk({tag, ".mem_valid_drop"}, {63'h0, o_mem_valid}, 64'h0);
    step();
    m_rvalid = 1'b0;
    chk({tag, ".resp_valid"}, {63'h0, o_resp_valid}, 64'h1);
    chk({tag, ".resp_err"}, {63'h0, o_resp_err}, 64'h0);
    chk({tag, ".resp_rdata"}, o_resp_rdata, exp_data);
    step();
    chk({tag, ".resp_pulse"}, {63'h0, o_resp_valid}, 64'h0);
    chk({tag, ".ready_again"}, {63'h0, o_req_ready}, 64'h1);
  endtask

  // Store with mem_ready immediate: resp_valid on the 2nd edge.
  task automatic do_store(input string tag, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [63:0] wd, input logic [31:0] exp_addr,
                          input logic [63:0] exp_wdata, input logic [7:0] exp_mask);
    issue(1'b1, f3, addr, wd);
    chk({tag, ".mem_valid"}, {63'h0, o_mem_valid}, 64'h1);
    chk({tag, ".mem_we"}, {63'h0, o_mem_we}, 64'h1);
    chk({tag, ".mem_addr"}, {32'h0, o_mem_addr}, {32'h0, exp_addr});
    chk({tag, ".mem_wdata"}, o_mem_wdata, exp_wdata);
    chk({tag, ".mem_wmask"}, {56'h0, o_mem_wmask}, {56'h0, exp_mask});
    chk({tag, ".early_resp"}, {63'h0, o_resp_valid}, 64'h0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk({tag, ".resp_valid"}, {63'h0, o_resp_valid}, 64'h1);
    chk({tag, ".resp_err"}, {63'h0, o_resp_err}, 64'h0);
    chk({tag, ".resp_rdata"}, o_resp_rdata, 64'h0);
    chk({tag, ".mem_valid_drop"}, {63'h0, o_mem_valid}, 64'h0);
    step();
    chk({tag, ".resp_pulse"}, {63'h0, o_resp_valid}, 64'h0);
  endtask

  // Request that must be rejected straight from IDLE with no memory traffic.
  task automatic do_err(input string tag, input logic st, input logic [2:0] f3,
                        input logic [31:0] addr);
    issue(st, f3, addr, 64'h0);
    chk({tag, ".mem_valid"}, {63'h0, o_mem_valid}, 64'h0);
    chk({tag, ".resp_valid"}, {63'h0, o_resp_valid}, 64'h1);
    chk({tag, ".resp_err"}, {63'h0, o_resp_err}, 64'h1);
    chk({tag, ".resp_rdata"}, o_resp_rdata, 64'h0);
    step();
    chk({tag, ".resp_pulse"}, {63'h0, o_resp_valid}, 64'h0);
    chk({tag, ".mem_valid_after"}, {63'h0, o_mem_valid}, 64'h0);
    chk({tag, ".ready_again"}, {63'h0, o_req_ready}, 64'h1);
  endtask

  initial begin
    sel = 1'b0; reset = 1'b1;
    r_valid = 1'b0; r_store = 1'b0; r_f3 = 3'b0; r_addr = 32'h0; r_wdata = 64'h0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = 64'h0;
    step();
    step();
    for (int s = 0; s < 2; s++) begin
      sel = s[0];
      chk("rst.req_ready", {63'h0, o_req_ready}, 64'h1);
      chk("rst.resp_valid", {63'h0, o_resp_valid}, 64'h0);
      chk("rst.resp_err", {63'h0, o_resp_err}, 64'h0);
      chk("rst.resp_rdata", o_resp_rdata, 64'h0);
      chk("rst.mem_valid", {63'h0, o_mem_valid}, 64'h0);
      chk("rst.mem_we", {63'h0, o_mem_we}, 64'h0);
      chk("rst.mem_wmask", {56'h0, o_mem_wmask}, 64'h0);
    end
    reset = 1'b0;
    sel = 1'b0;
    step();

    // ---------------- DATA_W = 32 ----------------
    do_load("a.lbu", 3'b100, 32'h8000_0003, 32'h8000_0000, 8'h08, 64'hAB00_0000, 64'h0000_00AB);
    do_load("a.lb",  3'b000, 32'h8000_0003, 32'h8000_0000, 8'h08, 64'hAB00_0000, 64'hFFFF_FFAB);
    do_load("a.lhu", 3'b101, 32'h8000_0002, 32'h8000_0000, 8'h0C, 64'h8001_0000, 64'h0000_8001);
    do_load("a.lh",  3'b001, 32'h8000_0002, 32'h8000_0000, 8'h0C, 64'h8001_0000, 64'hFFFF_8001);
    do_store("a.sh", 3'b001, 32'h8000_0002, 64'h1234_BEEF, 32'h8000_0000, 64'hBEEF_0000, 8'h0C);
    do_store("a.sb", 3'b000, 32'h8000_0001, 64'h0000_00A5, 32'h8000_0000, 64'h0000_A500, 8'h02);
    do_store("a.sw", 3'b010, 32'h0000_0004, 64'hDEAD_BEEF, 32'h0000_0004, 64'hDEAD_BEEF, 8'h0F);
    do_err("a.ld_illegal", 1'b0, 3'b011, 32'h0000_0010);
    do_err("a.f3_111", 1'b0, 3'b111, 32'h0000_0010);
`ifdef LSU_MISALIGN_EXC_EN
    do_err("a.lw_mis", 1'b0, 3'b010, 32'h0000_0081);
    do_err("a.sw_mis", 1'b1, 3'b010, 32'h0000_0083);
`else
    do_load("a.lw_mis", 3'b010, 32'h0000_0081, 32'h0000_0080, 8'h0E, 64'h8033_2211, 64'h0080_3322);
    do_store("a.sw_mis", 3'b010, 32'h0000_0083, 64'h1122_3344, 32'h0000_0080, 64'h4400_0000, 8'h08);
`endif

    // Back-pressure: mem_ready low for 3 cycles, request fields must hold.
    issue(1'b1, 3'b010, 32'h0000_0008, 64'hCAFE_F00D);
    for (int i = 0; i < 3; i++) begin
      chk("a.stall.mem_valid", {63'h0, o_mem_valid}, 64'h1);
      chk("a.stall.mem_we", {63'h0, o_mem_we}, 64'h1);
      chk("a.stall.mem_addr", {32'h0, o_mem_addr}, 64'h8);
      chk("a.stall.mem_wdata", o_mem_wdata, 64'hCAFE_F00D);
      chk("a.stall.mem_wmask", {56'h0, o_mem_wmask}, 64'h0F);
      chk("a.stall.resp_valid", {63'h0, o_resp_valid}, 64'h0);
      step();
    end
    chk("a.stall.mem_valid4", {63'h0, o_mem_valid}, 64'h1);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("a.stall.resp_valid", {63'h0, o_resp_valid}, 64'h1);
    chk("a.stall.resp_err", {63'h0, o_resp_err}, 64'h0);
    step();

    // Reset while in WAIT_R abandons the load.
    issue(1'b0, 3'b010, 32'h0000_0000, 64'h0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    chk("a.rst_wr.in_wait", {63'h0, o_req_ready}, 64'h0);
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("a.rst_wr.req_ready", {63'h0, o_req_ready}, 64'h1);
    chk("a.rst_wr.resp_valid", {63'h0, o_resp_valid}, 64'h0);
    chk("a.rst_wr.mem_valid", {63'h0, o_mem_valid}, 64'h0);
    // A stray mem_rvalid in IDLE must not produce a response.
    m_rvalid = 1'b1;
    m_rdata  = 64'h5555_5555;
    step();
    m_rvalid = 1'b0;
    chk("a.late_rv.resp_valid", {63'h0, o_resp_valid}, 64'h0);
    chk("a.late_rv.req_ready", {63'h0, o_req_ready}, 64'h1);
    step();
    chk("a.late_rv.resp_valid2", {63'h0, o_resp_valid}, 64'h0);

    // ---------------- DATA_W = 64, TIMEOUT = 4 ----------------
    sel = 1'b1;
    step();
    do_load("b.ld",  3'b011, 32'h0000_0010, 32'h0000_0010, 8'hFF,
            64'h8000_0000_0000_0001, 64'h8000_0000_0000_0001);
    do_load("b.lw",  3'b010, 32'h0000_0014, 32'h0000_0010, 8'hF0,
            64'h8000_0000_0000_0001, 64'hFFFF_FFFF_8000_0000);
    do_load("b.lwu", 3'b110, 32'h0000_0014, 32'h0000_0010, 8'hF0,
            64'h8000_0000_0000_0001, 64'h0000_0000_8000_0000);
    do_store("b.sd", 3'b011, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 32'h0000_0008,
             64'h0123_4567_89AB_CDEF, 8'hFF);
    do_store("b.sh", 3'b001, 32'h0000_0006, 64'h0000_0000_0000_BEEF, 32'h0000_0000,
             64'hBEEF_0000_0000_0000, 8'hC0);
    do_err("b.f3_111", 1'b0, 3'b111, 32'h0000_0000);
`ifdef LSU_MISALIGN_EXC_EN
    do_err("b.ld_mis", 1'b0, 3'b011, 32'h0000_0003);
`else
    do_load("b.ld_mis", 3'b011, 32'h0000_0003, 32'h0000_0000, 8'hF8,
            64'h1122_3344_5566_7788, 64'h0000_0011_2233_4455);
`endif

    // Read data never returns: error after 4 WAIT_R cycles.
    issue(1'b0, 3'b011, 32'h0000_0020, 64'h0);
    m_ready = 1'b1;
    step();
    m_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("b.to_wr.no_resp", {63'h0, o_resp_valid}, 64'h0);
      step();
    end
    chk("b.to_wr.resp_valid", {63'h0, o_resp_valid}, 64'h1);
    chk("b.to_wr.resp_err", {63'h0, o_resp_err}, 64'h1);
    chk("b.to_wr.resp_rdata", o_resp_rdata, 64'h0);
    step();
    chk("b.to_wr.ready_again", {63'h0, o_req_ready}, 64'h1);

    // mem_ready never comes: error after 4 REQ cycles, mem_valid dropped.
    issue(1'b1, 3'b011, 32'h0000_0040, 64'h1);
    for (int i = 0; i < 4; i++) begin
      chk("b.to_req.mem_valid", {63'h0, o_mem_valid}, 64'h1);
      chk("b.to_req.no_resp", {63'h0, o_resp_valid}, 64'h0);
      step();
    end
    chk("b.to_req.resp_valid", {63'h0, o_resp_valid}, 64'h1);
    chk("b.to_req.resp_err", {63'h0, o_resp_err}, 64'h1);
    chk("b.to_req.mem_valid_drop", {63'h0, o_mem_valid}, 64'h0);
    step();
    chk("b.to_req.resp_pulse", {63'h0, o_resp_valid}, 64'h0);

    // A clean transaction still completes after the timeouts.
    do_load("b.lbu_after", 3'b100, 32'h0000_0007, 32'h0000_0000, 8'h80,
            64'hFE00_0000_0000_0000, 64'h0000_0000_0000_00FE);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
